// File: rtl/pipe_pkg.sv
// Shared types for the integer-pipeline forwarding scoreboard.
package pipe_pkg;

  // Entry fields are sized for the widest supported configuration.
  // Narrower register/latency fields are zero-extended on the way in.
  localparam int FWD_RD_W  = 8;
  localparam int FWD_LAT_W = 4;

  // Select value meaning "read the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                 valid;
    logic [FWD_RD_W-1:0]  rd;
    logic                 we;
    logic [FWD_LAT_W-1:0] lat;
  } fwd_entry_t;

  // Bits needed to encode 0 (register file) .. depth (oldest stage).
  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority search for one source operand over the tracked stages.
// The youngest matching producer decides alone: it is forwarded if its
// result is ready, otherwise the operand stalls (no fallback to older ones).
module fwd_match
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 2
) (
  input  logic                        i_used,
  input  logic [REG_AW-1:0]           i_addr,
  input  fwd_entry_t [DEPTH-1:0]      i_ent,
  output logic [SEL_W-1:0]            o_sel,
  output logic                        o_stall
);

  logic w_found;

  // Scan stage 1 upward; first hit wins and freezes the result.
  always_comb begin
    o_sel   = SEL_W'(FWD_RF);
    o_stall = 1'b0;
    w_found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_found && i_used && i_ent[k].valid && i_ent[k].we &&
          (i_ent[k].rd != '0) && (i_ent[k].rd == FWD_RD_W'(i_addr))) begin
        w_found = 1'b1;
        if (int'(i_ent[k].lat) <= k + 1) o_sel   = SEL_W'(k + 1);
        else                              o_stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding / hazard controller beside EXE: tracks in-flight destinations
// through DEPTH post-EXE stages, emits per-operand bypass selects, a stall,
// and a saturating stall-cycle counter.
// Supports REG_AW <= 8 and LAT_W <= 4 (entry field widths in pipe_pkg).
module fwd_scoreboard
  import pipe_pkg::*;
#(
  parameter int  REG_AW = 5,
  parameter int  NSRC   = 2,
  parameter int  DEPTH  = 3,
  parameter int  LAT_W  = 2,
  parameter int  CNT_W  = 16,
  localparam int SEL_W  = sel_width(DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_advance,
  input  logic                      i_flush,
  input  logic                      i_ex_valid,
  input  logic [REG_AW-1:0]         i_ex_rd,
  input  logic                      i_ex_we,
  input  logic [LAT_W-1:0]          i_ex_lat,
  input  logic [NSRC-1:0]           i_src_used,
  input  logic [NSRC*REG_AW-1:0]    i_src_addr,
  output logic [NSRC*SEL_W-1:0]     o_fwd_sel,
  output logic                      o_stall,
  output logic [CNT_W-1:0]          o_stall_cnt
);

  // r_ent[0] is stage 1 (EXE/MEM), r_ent[DEPTH-1] is the oldest stage.
  fwd_entry_t [DEPTH-1:0] r_ent;
  fwd_entry_t             w_ins;
  logic [NSRC-1:0]        w_op_stall;
  logic [LAT_W-1:0]       w_ex_lat;
  logic [CNT_W-1:0]       r_cnt;

  // One priority search per source operand.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_match (
      .i_used  (i_src_used[i]),
      .i_addr  (i_src_addr[i*REG_AW +: REG_AW]),
      .i_ent   (r_ent),
      .o_sel   (o_fwd_sel[i*SEL_W +: SEL_W]),
      .o_stall (w_op_stall[i])
    );
  end

  // A squashed or empty EXE slot never stalls; flush beats a pending stall.
  assign o_stall  = i_ex_valid & ~i_flush & (|w_op_stall);
  assign w_ex_lat = (i_ex_lat == '0) ? LAT_W'(1) : i_ex_lat;

  // Stage-1 insert: a stalled or flushed instruction becomes a bubble.
  always_comb begin
    w_ins       = '0;
    w_ins.valid = i_ex_valid & ~i_flush & ~o_stall;
    w_ins.rd    = FWD_RD_W'(i_ex_rd);
    w_ins.we    = i_ex_we;
    w_ins.lat   = FWD_LAT_W'(w_ex_lat);
  end

  // Entry shift register: moves only when the pipeline advances.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ent <= '0;
    end else if (i_advance) begin
      for (int k = DEPTH - 1; k > 0; k--) r_ent[k] <= r_ent[k-1];
      r_ent[0] <= w_ins;
    end
  end

  // Stall-cycle counter: counts advancing stall cycles, saturates at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_advance && o_stall && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed + random check of fwd_scoreboard against a history-based model:
// the model remembers what entered stage 1 on each advancing edge, so a
// producer issued k advances ago sits in stage k and is ready once k >= lat.
module tb_fwd_scoreboard;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int DP = 3;
  localparam int LW = 2;
  localparam int CW = 8;   // small counter so saturation is reachable quickly
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst, adv, flush, exv, exwe;
  logic [AW-1:0]     exrd;
  logic [LW-1:0]     exlat;
  logic [NS-1:0]     used;
  logic [NS*AW-1:0]  saddr;
  logic [NS*SW-1:0]  sel;
  logic              stall;
  logic [CW-1:0]     cnt;

  fwd_scoreboard #(
    .REG_AW (AW), .NSRC (NS), .DEPTH (DP), .LAT_W (LW), .CNT_W (CW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_advance   (adv),
    .i_flush     (flush),
    .i_ex_valid  (exv),
    .i_ex_rd     (exrd),
    .i_ex_we     (exwe),
    .i_ex_lat    (exlat),
    .i_src_used  (used),
    .i_src_addr  (saddr),
    .o_fwd_sel   (sel),
    .o_stall     (stall),
    .o_stall_cnt (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    bit we;
    int lat;
  } rec_t;

  rec_t           hist[$];
  logic [NS*SW-1:0] m_sel;
  logic           m_stall;
  int             m_cnt;
  logic [NS*SW-1:0] last_sel;
  logic           last_stall;
  int             total = 0;
  int             bad = 0;

  task automatic model_reset();
    rec_t r;
    r.v = 0; r.rd = 0; r.we = 0; r.lat = 1;
    hist.delete();
    for (int k = 0; k < DP; k++) hist.push_back(r);
    m_cnt = 0;
  endtask

  task automatic model_eval();
    bit any_st;
    any_st = 0;
    m_sel  = '0;
    for (int i = 0; i < NS; i++) begin
      int a;
      a = int'(saddr[i*AW +: AW]);
      if (used[i]) begin
        for (int k = 1; k <= DP; k++) begin
          rec_t r;
          r = hist[hist.size() - k];
          if (r.v && r.we && r.rd != 0 && r.rd == a) begin
            if (k >= r.lat) m_sel[i*SW +: SW] = SW'(k);
            else            any_st = 1;
            break;
          end
        end
      end
    end
    m_stall = exv && !flush && any_st;
  endtask

  task automatic expect_val(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One pipeline cycle: drive, check combinational outputs and counter,
  // then clock and advance the model.
  task automatic step(input bit r_v, input bit a_v, input bit f_v, input bit v_v,
                      input int rd_v, input bit we_v, input int lat_v,
                      input logic [NS-1:0] u_v, input int a0, input int a1,
                      input string tag);
    @(negedge clk);
    rst = r_v; adv = a_v; flush = f_v; exv = v_v;
    exrd = AW'(rd_v); exwe = we_v; exlat = LW'(lat_v); used = u_v;
    saddr = {AW'(a1), AW'(a0)};
    #1;
    model_eval();
    last_sel = sel; last_stall = stall;
    total++;
    assert (sel === m_sel) else begin
      bad++; $error("FAIL %s sel got=%h exp=%h", tag, sel, m_sel);
    end
    total++;
    assert (stall === m_stall) else begin
      bad++; $error("FAIL %s stall got=%b exp=%b", tag, stall, m_stall);
    end
    total++;
    assert (int'(cnt) === m_cnt) else begin
      bad++; $error("FAIL %s stall_cnt got=%0d exp=%0d", tag, cnt, m_cnt);
    end
    @(posedge clk);
    if (r_v) begin
      model_reset();
    end else if (a_v) begin
      rec_t r;
      r.v = v_v && !f_v && !m_stall;
      r.rd = rd_v; r.we = we_v; r.lat = (lat_v == 0) ? 1 : lat_v;
      hist.push_back(r);
      void'(hist.pop_front());
      if (m_stall && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endtask

  initial begin
    rst = 1; adv = 0; flush = 0; exv = 0; exrd = '0; exwe = 0; exlat = '0;
    used = '0; saddr = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset state
    step(0,1,0,0, 0,0,1, 2'b11, 5, 7, "reset_state");
    expect_val("reset_sel", int'(last_sel), 0);
    expect_val("reset_stall", int'(last_stall), 0);

    // ALU producer x5, forwarded from stage 1 then stage 2
    step(0,1,0,1, 5,1,1, 2'b00, 0, 0, "alu_x5");
    step(0,1,0,1, 6,1,1, 2'b01, 5, 0, "fwd_s1");
    expect_val("fwd_s1_sel0", int'(last_sel[1:0]), 1);
    step(0,1,0,1, 0,0,1, 2'b01, 5, 0, "fwd_s2");
    expect_val("fwd_s2_sel0", int'(last_sel[1:0]), 2);

    // load-use: one stall, then forward from stage 2
    step(0,1,0,1, 7,1,2, 2'b00, 0, 0, "load_x7");
    step(0,1,0,1, 8,1,1, 2'b10, 0, 7, "load_use");
    expect_val("load_use_stall", int'(last_stall), 1);
    step(0,1,0,1, 8,1,1, 2'b10, 0, 7, "load_use_fwd");
    expect_val("load_use_sel1", int'(last_sel[3:2]), 2);
    expect_val("load_use_cnt", int'(cnt), 1);

    // two producers of x3: youngest wins
    step(0,1,0,1, 3,1,1, 2'b00, 0, 0, "x3_old");
    step(0,1,0,1, 3,1,1, 2'b00, 0, 0, "x3_young");
    step(0,1,0,1, 0,0,1, 2'b11, 3, 3, "x3_youngest");
    step(0,1,0,1, 3,1,1, 2'b00, 0, 0, "x3_ready");
    step(0,1,0,1, 3,1,3, 2'b00, 0, 0, "x3_lat3");
    step(0,1,0,1, 0,0,1, 2'b01, 3, 0, "x3_no_fallback");
    expect_val("no_fallback_stall", int'(last_stall), 1);

    // x0 producer and unused operand never match
    step(0,1,0,1, 0,1,1, 2'b00, 0, 0, "x0_prod");
    step(0,1,0,1, 0,0,1, 2'b11, 0, 0, "x0_read");
    step(0,1,0,1, 4,1,1, 2'b00, 0, 0, "x4_prod");
    step(0,1,0,1, 0,0,1, 2'b00, 4, 4, "x4_unused");

    // flushed load never becomes a producer; flush masks a pending stall
    step(0,1,1,1, 9,1,2, 2'b00, 0, 0, "x9_flushed");
    step(0,1,0,1, 0,0,1, 2'b01, 9, 0, "x9_after_flush");
    expect_val("flush_sel0", int'(last_sel[1:0]), 0);
    step(0,1,0,1, 9,1,2, 2'b00, 0, 0, "x9_load");
    step(0,1,1,1, 0,0,1, 2'b01, 9, 0, "flush_over_stall");
    expect_val("flush_stall", int'(last_stall), 0);

    // advance=0 holds entries and counter
    step(0,1,0,1, 10,1,2, 2'b00, 0, 0, "x10_load");
    step(0,0,0,1, 0,0,1, 2'b10, 0, 10, "hold1");
    step(0,0,0,1, 0,0,1, 2'b10, 0, 10, "hold2");
    step(0,1,0,1, 0,0,1, 2'b10, 0, 10, "hold_release");

    // mid-run reset discards three valid entries
    step(0,1,0,1, 11,1,1, 2'b00, 0, 0, "x11");
    step(0,1,0,1, 12,1,1, 2'b00, 0, 0, "x12");
    step(0,1,0,1, 13,1,3, 2'b00, 0, 0, "x13");
    step(1,1,0,1, 14,1,1, 2'b11, 11, 13, "rst_pulse");
    step(0,0,0,1, 0,0,1, 2'b11, 12, 13, "after_rst");
    expect_val("after_rst_sel", int'(last_sel), 0);
    expect_val("after_rst_cnt", int'(cnt), 0);

    // counter saturation: self-dependent lat=3 chain stalls 2 of every 3 cycles
    for (int n = 0; n < 420; n++)
      step(0,1,0,1, 1,1,3, 2'b01, 1, 0, "sat_loop");
    expect_val("sat_cnt", int'(cnt), (1 << CW) - 1);

    // randomized traffic over a small register window
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) != 0),
           ($urandom_range(7) == 0), ($urandom_range(5) != 0),
           int'($urandom_range(3)), bit'($urandom_range(3) != 0),
           int'($urandom_range(3)), NS'($urandom_range(3)),
           int'($urandom_range(3)), int'($urandom_range(3)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
